c64_cia_timer: RTL
==================

C64_CIA_TIMER -- requirements
Module: c64_cia_timer

Interface
REQ-001 The parameter list SHALL be: BASE, 16'hDC00, base address of the 16-byte register window.
REQ-002 clk  input  1  system clock; one CPU bus cycle per rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 ab  input  16  CPU address bus, combinational from the CPU.
REQ-005 wdata  input  8  CPU write data (CPU "do").
REQ-006 we  input  1  CPU write enable, combinational from the CPU.
REQ-007 rdata  output  8  read data to the CPU data-in mux; combinational.
REQ-008 sel  output  1  high when ab[15:4] == BASE[15:4]; steers the system read mux.
REQ-009 irq  output  1  registered interrupt request, active-high.

Function
REQ-010 Register offsets on ab[3:0] SHALL be: 4 TA_LO, 5 TA_HI, 6 TB_LO, 7 TB_HI, D ICR, E CRA, F CRB; all other offsets read 8'h00 and ignore writes.
REQ-011 A register write SHALL occur on the rising clk edge when sel=1 and we=1.
REQ-012 rdata SHALL be valid in the same cycle as ab: TA/TB read the live counter bytes, CRA/CRB read back with bit4 as 0, ICR reads {irq, 5'b0, flagB, flagA}, and non-selected cycles drive 8'h00.
REQ-013 Each timer SHALL hold a 16-bit latch and a 16-bit counter; writes to LO/HI offsets update the latch only.
REQ-014 A write to a HI offset while that timer's START bit = 0 SHALL also copy the updated latch into the counter at the same edge.
REQ-015 CRx bit0 = START, bit3 = ONESHOT, bit4 = FORCE LOAD strobe (counter <= latch at the write edge; not stored), CRB bits6:5 = source (00 clk, 10 Timer A underflow, others count clk).
REQ-016 While START=1 the counter SHALL decrement by 1 per count event; when the counter is 0 at a count event it SHALL instead reload from the latch and raise underflow for that edge; period = latch+1 events.
REQ-017 On underflow with ONESHOT=1, START SHALL clear at the same edge; the reload still occurs.
REQ-018 Timer B in source 10 SHALL count only in cycles where Timer A underflows at that edge (same-edge chaining, no extra latency).
REQ-019 Underflow of timer A/B SHALL set flagA/flagB; the flag SHALL stay set until cleared by an ICR read.
REQ-020 An ICR write SHALL update the 2-bit mask: bit7=1 sets the mask bits given as 1 in bits1:0, bit7=0 clears them.
REQ-021 irq SHALL be registered as |(flags_next & mask_next), rising at the same edge a masked flag sets.
REQ-022 An ICR read (sel, we=0, ab[3:0]=D) SHALL clear both flags at the end of the cycle; an underflow at that same edge SHALL win (flag stays set).
REQ-023 Counter wrap: latch 0 SHALL underflow on every count event.
REQ-024 Simultaneous FORCE LOAD and underflow SHALL both load from the new latch value.

Reset
REQ-025 reset SHALL immediately clear: latches to 16'hFFFF, counters to 16'hFFFF, CRA/CRB to 0, mask to 0, flags to 0, irq to 0.
REQ-026 Reset asserted mid-count SHALL abort counting; after release no underflow occurs until START is written.

Structure
REQ-027 Register offsets, CR bit positions and the default BASE SHALL live in the shared package c64_bus_pkg.
REQ-028 One sub-module, cia_timer_counter (latch, counter, START/ONESHOT, underflow output), SHALL be instantiated twice.

Verification
REQ-029 Write TA_LO=03, TA_HI=00, CRA=01 -> TA reads 3,2,1,0,3 on consecutive cycles; flagA sets at the 0->3 edge.
REQ-030 Write ICR=81, run TA with latch 2 -> irq rises at the first underflow edge; an ICR read returns 8'h81 and irq falls at the next edge.
REQ-031 CRA=09 (one-shot), latch 1 -> one underflow, START reads 0, counter holds 1.
REQ-032 Set TA latch 1, TB latch 2, CRB=41, CRA=01 -> flagB sets after 6 clk.
REQ-033 Perform an ICR read on the exact edge of a TA underflow -> flagA remains 1.
REQ-034 Assert reset while TA=5 is running -> all reads return FFFF/00 and irq=0 immediately.

Source files
------------

// File: rtl/c64_bus_pkg.sv
// Shared CIA register map: offsets, control-register bit positions, default base.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package c64_bus_pkg;

  localparam logic [15:0] CIA_BASE_DEFAULT = 16'hDC00;

  // Register offsets within the 16-byte window (ab[3:0]).
  localparam logic [3:0] OFF_TA_LO = 4'h4;
  localparam logic [3:0] OFF_TA_HI = 4'h5;
  localparam logic [3:0] OFF_TB_LO = 4'h6;
  localparam logic [3:0] OFF_TB_HI = 4'h7;
  localparam logic [3:0] OFF_ICR   = 4'hD;
  localparam logic [3:0] OFF_CRA   = 4'hE;
  localparam logic [3:0] OFF_CRB   = 4'hF;

  // Control register bit positions.
  localparam int CR_START    = 0;
  localparam int CR_ONESHOT  = 3;
  localparam int CR_FORCE    = 4;
  localparam int CRB_SRC_LSB = 5;

  // CRB source encoding that chains Timer B onto Timer A underflows.
  localparam logic [1:0] SRC_TA_UF = 2'b10;

  // Interrupt flag / mask bit positions.
  localparam int FLAG_A = 0;
  localparam int FLAG_B = 1;

  // FORCE LOAD is a strobe, so it is never stored in the control register.
  function automatic logic [7:0] cr_store(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    r[CR_FORCE] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/cia_timer_counter.sv
// One CIA interval timer: 16-bit latch, 16-bit down-counter, control register.
// Latency: register writes take effect at the write edge; underflow is combinational.
// Backpressure: none; bus writes and count events are always accepted.
module cia_timer_counter
  import c64_bus_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cnt_evt,
  input  logic        lo_we,
  input  logic        hi_we,
  input  logic        cr_we,
  input  logic [7:0]  wdata,
  output logic [15:0] count,
  output logic [7:0]  cr,
  output logic        underflow
);

  logic [15:0] latch_q, latch_d;
  logic [15:0] count_q, count_d;
  logic [7:0]  cr_q, cr_d;

  // Underflow is the count event that finds the counter already at zero.
  assign underflow = cr_q[CR_START] & cnt_evt & (count_q == 16'h0000);
  assign count     = count_q;
  assign cr        = cr_q;

  // Next-state: latch writes, control writes, counting, reload and load strobes.
  always_comb begin
    latch_d = latch_q;
    if (lo_we) latch_d[7:0]  = wdata;
    if (hi_we) latch_d[15:8] = wdata;

    cr_d = cr_q;
    if (cr_we) cr_d = cr_store(wdata);
    if (underflow && cr_q[CR_ONESHOT]) cr_d[CR_START] = 1'b0;

    // Reloads use latch_d so a latch write on the reload edge is honoured.
    count_d = count_q;
    if (cr_q[CR_START] && cnt_evt) count_d = underflow ? latch_d : count_q - 16'd1;
    if (hi_we && !cr_q[CR_START])  count_d = latch_d;
    if (cr_we && wdata[CR_FORCE])  count_d = latch_d;
  end

  // State registers; reset parks the timer stopped with all-ones latch/counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      latch_q <= 16'hFFFF;
      count_q <= 16'hFFFF;
      cr_q    <= 8'h00;
    end else begin
      latch_q <= latch_d;
      count_q <= count_d;
      cr_q    <= cr_d;
    end
  end

endmodule

// File: rtl/c64_cia_timer.sv
// CIA timer pair with interrupt control on a 16-byte CPU register window.
// Latency: reads combinational same cycle; writes at the edge; irq registered.
// Backpressure: none; every CPU bus cycle completes in one clock.
module c64_cia_timer
  import c64_bus_pkg::*;
#(
  parameter logic [15:0] BASE = CIA_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ab,
  input  logic [7:0]  wdata,
  input  logic        we,
  output logic [7:0]  rdata,
  output logic        sel,
  output logic        irq
);

  logic [3:0]  off;
  logic        wr;
  logic        icr_rd;
  logic        ta_uf, tb_uf, tb_evt;
  logic [15:0] ta_cnt, tb_cnt;
  logic [7:0]  cra, crb;
  logic [1:0]  flags_q, flags_d;
  logic [1:0]  mask_q, mask_d;
  logic        irq_q, irq_d;

  assign off    = ab[3:0];
  assign sel    = (ab[15:4] == BASE[15:4]);
  assign wr     = sel & we;
  assign icr_rd = sel & ~we & (off == OFF_ICR);
  assign irq    = irq_q;

  // Timer B either counts every clock or only on Timer A underflow edges.
  assign tb_evt = (crb[CRB_SRC_LSB+1:CRB_SRC_LSB] == SRC_TA_UF) ? ta_uf : 1'b1;

  cia_timer_counter u_timer_a (
    .clk       (clk),
    .reset     (reset),
    .cnt_evt   (1'b1),
    .lo_we     (wr && off == OFF_TA_LO),
    .hi_we     (wr && off == OFF_TA_HI),
    .cr_we     (wr && off == OFF_CRA),
    .wdata     (wdata),
    .count     (ta_cnt),
    .cr        (cra),
    .underflow (ta_uf)
  );

  cia_timer_counter u_timer_b (
    .clk       (clk),
    .reset     (reset),
    .cnt_evt   (tb_evt),
    .lo_we     (wr && off == OFF_TB_LO),
    .hi_we     (wr && off == OFF_TB_HI),
    .cr_we     (wr && off == OFF_CRB),
    .wdata     (wdata),
    .count     (tb_cnt),
    .cr        (crb),
    .underflow (tb_uf)
  );

  // Flags clear on ICR read but an underflow on the same edge wins; irq follows next state.
  always_comb begin
    flags_d = flags_q;
    if (icr_rd) flags_d = 2'b00;
    if (ta_uf)  flags_d[FLAG_A] = 1'b1;
    if (tb_uf)  flags_d[FLAG_B] = 1'b1;

    mask_d = mask_q;
    if (wr && off == OFF_ICR) begin
      if (wdata[7]) mask_d = mask_q | wdata[1:0];
      else          mask_d = mask_q & ~wdata[1:0];
    end

    irq_d = |(flags_d & mask_d);
  end

  // Interrupt state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= 2'b00;
      mask_q  <= 2'b00;
      irq_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      mask_q  <= mask_d;
      irq_q   <= irq_d;
    end
  end

  // Read mux: live counters, control readback, ICR status; zero when not selected.
  always_comb begin
    rdata = 8'h00;
    if (sel) begin
      case (off)
        OFF_TA_LO: rdata = ta_cnt[7:0];
        OFF_TA_HI: rdata = ta_cnt[15:8];
        OFF_TB_LO: rdata = tb_cnt[7:0];
        OFF_TB_HI: rdata = tb_cnt[15:8];
        OFF_ICR:   rdata = {irq_q, 5'b00000, flags_q[FLAG_B], flags_q[FLAG_A]};
        OFF_CRA:   rdata = cra;
        OFF_CRB:   rdata = crb;
        default:   rdata = 8'h00;
      endcase
    end
  end

endmodule
